// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues in-order imem reads at pc_in, pairs each response with its PC
// in a circular buffer and presents {pc, instr} to decode; a flush drops buffered and in-flight fetches.
module fetch_stage #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_write_enable,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   read_ptr;
  logic [PW-1:0]   drop_cnt;
  logic [PW-1:0]   used;
  logic [PW-1:0]   outstanding;
  logic [XLEN-1:0] pc_buf    [BUF_DEPTH];
  logic [XLEN-1:0] instr_buf [BUF_DEPTH];
  logic            req_fire;
  logic            resp_ok;
  logic            resp_keep;
  logic            consume;

  assign used        = alloc_ptr - read_ptr;
  assign outstanding = alloc_ptr - fill_ptr;

  // Space is judged on registered pointers only, so a consume frees a slot one cycle later.
  assign imem_req_valid  = rst_n & ~flush & (used < PW'(BUF_DEPTH));
  assign imem_req_addr   = pc_in;
  assign req_fire        = imem_req_valid & imem_req_ready;
  assign pc_write_enable = req_fire;

  assign resp_ok   = imem_resp_valid & (outstanding != '0);
  assign resp_keep = resp_ok & ~flush & (drop_cnt == '0);

  assign if_valid = (read_ptr != fill_ptr) & (drop_cnt == '0) & ~flush;
  assign consume  = if_valid & id_ready;
  assign if_pc    = pc_buf[read_ptr[AW-1:0]];
  assign if_instr = instr_buf[read_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (req_fire) begin
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (resp_ok) begin
        fill_ptr <= fill_ptr + PW'(1);
      end
      // Flush skips everything already returned and schedules the rest of the in-flight reads for dropping.
      if (flush) begin
        read_ptr <= fill_ptr + PW'(resp_ok);
        drop_cnt <= outstanding - PW'(resp_ok);
      end else if (resp_ok && (drop_cnt != '0)) begin
        read_ptr <= read_ptr + PW'(1);
        drop_cnt <= drop_cnt - PW'(1);
      end else if (consume) begin
        read_ptr <= read_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_buf[alloc_ptr[AW-1:0]] <= pc_in;
    end
    if (resp_keep) begin
      instr_buf[fill_ptr[AW-1:0]] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays pc_logic and a fixed/variable-latency in-order
// instruction memory, and checks outputs against hand-derived values plus an in-order PC scoreboard.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        pc_write_enable;
   logic        flush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        id_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          lat         = 1;
   int          last_due    = 0;
   logic [31:0] flush_target;
   logic [31:0] mem_addr_q [$];
   int          mem_due_q  [$];
   logic [31:0] exp_q      [$];

   fetch_stage #(.XLEN(32), .BUF_DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_in           (pc_in),
      .pc_write_enable (pc_write_enable),
      .flush           (flush),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .id_ready        (id_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr)
   );

   // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents are a fixed function of the address so every instruction is recognisable.
   function automatic logic [31:0] instrAt(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   // One comparison: counts it, and on a miss counts the failure and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Advances one clock: samples handshakes before the edge (scoreboard, memory queue, next PC),
   // then drives pc_in and the memory response for the new cycle just after the edge.
   task automatic applyStimulus();
      logic        acc;
      logic        cons;
      logic        fl;
      logic [31:0] a;
      logic [31:0] npc;
      logic [31:0] e;
      int          d;
      acc  = imem_req_valid & imem_req_ready;
      cons = if_valid & id_ready;
      fl   = flush;
      a    = imem_req_addr;
      if (cons) begin
         checkOutput("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_pc", if_pc, e);
            checkOutput("sb_instr", if_instr, instrAt(e));
         end
      end
      if (fl) exp_q.delete();
      if (acc) begin
         exp_q.push_back(a);
         d = cyc + lat;
         if (d <= last_due) d = last_due + 1;
         mem_addr_q.push_back(a);
         mem_due_q.push_back(d);
         last_due = d;
      end
      if (!rst_n)               npc = 32'h0;
      else if (fl)              npc = flush_target;
      else if (pc_write_enable) npc = pc_in + 32'd4;
      else                      npc = pc_in;
      @(posedge clk);
      cyc++;
      #1;
      pc_in = npc;
      if (!rst_n) begin
         mem_addr_q.delete();
         mem_due_q.delete();
         exp_q.delete();
         last_due        = 0;
         imem_resp_valid = 1'b0;
      end else if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = instrAt(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
   endtask

   // Asserts reset mid-cycle, checks the outputs drop at once, drops any pending memory traffic,
   // then releases with pc_in = 0 and checks the first request.
   task automatic doReset();
      rst_n           = 1'b0;
      flush           = 1'b0;
      imem_resp_valid = 1'b0;
      #1;
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_pc_we", 32'(pc_write_enable), 32'd0);
      checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_q.delete();
      last_due = 0;
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;
      #1;
      checkOutput("rel_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("rel_req_addr", imem_req_addr, 32'h0);
   endtask

   initial begin
      rst_n           = 1'b1;
      pc_in           = 32'h0;
      flush           = 1'b0;
      flush_target    = 32'h0;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      id_ready        = 1'b0;
      #2;
      doReset();

      // Streaming with a 1-cycle memory: one instruction per cycle after two cycles of fill.
      lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
      #1;
      checkOutput("st_c0_pc_we", 32'(pc_write_enable), 32'd1);
      checkOutput("st_c0_if_valid", 32'(if_valid), 32'd0);
      applyStimulus();
      #1;
      checkOutput("st_c1_pc_we", 32'(pc_write_enable), 32'd1);
      checkOutput("st_c1_addr", imem_req_addr, 32'h4);
      checkOutput("st_c1_if_valid", 32'(if_valid), 32'd0);
      applyStimulus();
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("st_if_valid", 32'(if_valid), 32'd1);
         checkOutput("st_if_pc", if_pc, 32'(4 * i));
         checkOutput("st_if_instr", if_instr, instrAt(32'(4 * i)));
         checkOutput("st_pc_we", 32'(pc_write_enable), 32'd1);
         applyStimulus();
      end

      // Backpressure: four requests fill the buffer, then fetch stalls until decode drains it.
      doReset();
      lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("bp_fill_addr", imem_req_addr, 32'(4 * i));
         checkOutput("bp_fill_pc_we", 32'(pc_write_enable), 32'd1);
         applyStimulus();
      end
      #1;
      checkOutput("bp_full_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("bp_full_pc_we", 32'(pc_write_enable), 32'd0);
      checkOutput("bp_full_if_pc", if_pc, 32'h0);
      applyStimulus();
      id_ready = 1'b1;
      #1;
      checkOutput("bp_consume_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("bp_consume_if_pc", if_pc, 32'h0);
      applyStimulus();
      #1;
      checkOutput("bp_resume_addr", imem_req_addr, 32'h10);
      checkOutput("bp_resume_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("bp_drain_pc4", if_pc, 32'h4);
      applyStimulus();
      #1;
      checkOutput("bp_drain_pc8", if_pc, 32'h8);
      applyStimulus();
      #1;
      checkOutput("bp_drain_pcc", if_pc, 32'hC);
      applyStimulus();
      #1;
      checkOutput("bp_next_pc10", if_pc, 32'h10);
      checkOutput("bp_next_instr10", if_instr, instrAt(32'h10));
      applyStimulus();

      // Flush with one buffered entry and two reads in flight on a 3-cycle memory.
      doReset();
      lat = 3; imem_req_ready = 1'b1; id_ready = 1'b0; flush_target = 32'h100;
      #1;
      checkOutput("fl_c0_addr", imem_req_addr, 32'h0);
      applyStimulus();
      imem_req_ready = 1'b0;
      #1;
      checkOutput("fl_c1_pc_we", 32'(pc_write_enable), 32'd0);
      applyStimulus();
      imem_req_ready = 1'b1;
      #1;
      checkOutput("fl_c2_addr", imem_req_addr, 32'h4);
      applyStimulus();
      #1;
      checkOutput("fl_c3_addr", imem_req_addr, 32'h8);
      applyStimulus();
      #1;
      checkOutput("fl_pre_if_valid", 32'(if_valid), 32'd1);
      checkOutput("fl_pre_if_pc", if_pc, 32'h0);
      flush = 1'b1;
      #1;
      checkOutput("fl_if_valid", 32'(if_valid), 32'd0);
      checkOutput("fl_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("fl_pc_we", 32'(pc_write_enable), 32'd0);
      applyStimulus();
      flush = 1'b0;
      #1;
      checkOutput("fl_target_addr", imem_req_addr, 32'h100);
      checkOutput("fl_target_req_valid", 32'(imem_req_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) imem_req_ready = 1'b0;
         #1;
         checkOutput("fl_drop_if_valid", 32'(if_valid), 32'd0);
         applyStimulus();
      end
      #1;
      checkOutput("fl_new_if_valid", 32'(if_valid), 32'd1);
      checkOutput("fl_new_if_pc", if_pc, 32'h100);
      checkOutput("fl_new_if_instr", if_instr, instrAt(32'h100));
      applyStimulus();

      // Flush in the same cycle as a response and id_ready: response dropped, nothing consumed.
      doReset();
      lat = 2; imem_req_ready = 1'b1; id_ready = 1'b0; flush_target = 32'h200;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      imem_req_ready = 1'b0;
      #1;
      checkOutput("fr_pre_if_pc", if_pc, 32'h0);
      flush = 1'b1; id_ready = 1'b1;
      #1;
      checkOutput("fr_if_valid", 32'(if_valid), 32'd0);
      applyStimulus();
      flush = 1'b0; imem_req_ready = 1'b1;
      #1;
      checkOutput("fr_c4_if_valid", 32'(if_valid), 32'd0);
      checkOutput("fr_c4_addr", imem_req_addr, 32'h200);
      checkOutput("fr_c4_req_valid", 32'(imem_req_valid), 32'd1);
      applyStimulus();
      #1;
      checkOutput("fr_c5_if_valid", 32'(if_valid), 32'd0);
      applyStimulus();
      imem_req_ready = 1'b0;
      #1;
      checkOutput("fr_c6_if_valid", 32'(if_valid), 32'd0);
      applyStimulus();
      #1;
      checkOutput("fr_c7_if_valid", 32'(if_valid), 32'd1);
      checkOutput("fr_c7_if_pc", if_pc, 32'h200);
      applyStimulus();
      #1;
      checkOutput("fr_c8_if_pc", if_pc, 32'h204);
      checkOutput("fr_c8_if_instr", if_instr, instrAt(32'h204));
      applyStimulus();

      // Reset while two reads are outstanding on a 3-cycle memory.
      doReset();
      lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
      applyStimulus();
      applyStimulus();
      #1;
      checkOutput("mr_pre_req_valid", 32'(imem_req_valid), 32'd1);
      doReset();

      // Random ready/latency/flush traffic checked by the in-order scoreboard, then a full drain.
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         id_ready       = ($urandom_range(0, 3) != 0);
         lat            = int'($urandom_range(1, 3));
         flush          = ($urandom_range(0, 39) == 0);
         if (flush) flush_target = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
         #1;
         applyStimulus();
      end
      flush = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         #1;
         applyStimulus();
      end
      #1;
      checkOutput("drain_sb_empty", 32'(exp_q.size()), 32'd0);
      checkOutput("drain_mem_empty", 32'(mem_due_q.size()), 32'd0);
      checkOutput("drain_if_valid", 32'(if_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
